// File: rtl/alu_issue_stage_pkg.sv
// Shared constants for the ALU issue stage and the logic unit's opcode decode.
// Holds the opcode encodings, state encodings and the legality helper.
package alu_issue_stage_pkg;

    localparam int unsigned OPC_W = 3;
    localparam int unsigned ST_W  = 2;

    localparam logic [OPC_W-1:0] OC_NA  = 3'b000;
    localparam logic [OPC_W-1:0] OC_NB  = 3'b001;
    localparam logic [OPC_W-1:0] OC_OR  = 3'b010;
    localparam logic [OPC_W-1:0] OC_AND = 3'b011;
    localparam logic [OPC_W-1:0] OC_XOR = 3'b100;
    localparam logic [OPC_W-1:0] OC_MAX = 3'b100;

    localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
    localparam logic [ST_W-1:0] ST_EXEC = 2'd1;
    localparam logic [ST_W-1:0] ST_RESP = 2'd2;

    typedef enum logic [ST_W-1:0] {
        S_IDLE = ST_IDLE,
        S_EXEC = ST_EXEC,
        S_RESP = ST_RESP
    } state_e;

    // Opcodes above OC_MAX reach the logic unit but are flagged, uncounted and never accumulated.
    function automatic logic oc_legal(input logic [OPC_W-1:0] op);
        return (op <= OC_MAX);
    endfunction

endpackage

// File: rtl/alu_issue_stage.sv
// Issue/retire stage around the external 16-bit logic unit: capture, one execute
// cycle, registered result with accumulator chaining and a saturating zero counter.
module alu_issue_stage
    import alu_issue_stage_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned ZCNT_W = 8
) (
    input  logic              iClk,
    input  logic              iRstN,
    input  logic              iValid,
    output logic              oReady,
    input  logic [WIDTH-1:0]  iA,
    input  logic [WIDTH-1:0]  iB,
    input  logic [OPC_W-1:0]  iOpcode,
    input  logic              iUseAcc,
    input  logic              iAccClr,
    output logic [WIDTH-1:0]  oLuA,
    output logic [WIDTH-1:0]  oLuB,
    output logic [OPC_W-1:0]  oLuOpcode,
    input  logic [WIDTH-1:0]  iLuX,
    input  logic              iLuZero,
    output logic              oValid,
    input  logic              iReady,
    output logic [WIDTH-1:0]  oX,
    output logic              oZero,
    output logic              oIllegal,
    output logic [ZCNT_W-1:0] oZeroCount
);

    localparam logic [ZCNT_W-1:0] ZCNT_MAX = '1;

    state_e              r_state;
    logic                r_ready;
    logic                r_valid;
    logic [WIDTH-1:0]    r_a;
    logic [WIDTH-1:0]    r_b;
    logic [OPC_W-1:0]    r_op;
    logic [WIDTH-1:0]    r_x;
    logic                r_zero;
    logic                r_illegal;
    logic [WIDTH-1:0]    r_acc;
    logic [ZCNT_W-1:0]   r_zcnt;

    logic [WIDTH-1:0]    w_acc_eff;
    logic                w_op_legal;

    // A same-edge clear makes the accumulator read as zero at capture.
    assign w_acc_eff  = iAccClr ? '0 : r_acc;
    assign w_op_legal = oc_legal(r_op);

    // FSM with operand, result, accumulator and counter registers.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            r_state   <= S_IDLE;
            r_ready   <= 1'b1;
            r_valid   <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_op      <= '0;
            r_x       <= '0;
            r_zero    <= 1'b0;
            r_illegal <= 1'b0;
            r_acc     <= '0;
            r_zcnt    <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (iValid) begin
                        r_a     <= iA;
                        r_op    <= iOpcode;
                        r_b     <= iUseAcc ? w_acc_eff : iB;
                        r_ready <= 1'b0;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_x       <= iLuX;
                    r_zero    <= iLuZero;
                    r_illegal <= ~w_op_legal;
                    if (w_op_legal) begin
                        r_acc <= iLuX;
                        if (iLuZero && (r_zcnt != ZCNT_MAX)) begin
                            r_zcnt <= r_zcnt + ZCNT_W'(1);
                        end
                    end
                    r_valid <= 1'b1;
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    if (iReady) begin
                        r_valid <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
            // Clear overrides any accumulator update on the same edge.
            if (iAccClr) begin
                r_acc <= '0;
            end
        end
    end

    assign oReady     = r_ready;
    assign oValid     = r_valid;
    assign oLuA       = r_a;
    assign oLuB       = r_b;
    assign oLuOpcode  = r_op;
    assign oX         = r_x;
    assign oZero      = r_zero;
    assign oIllegal   = r_illegal;
    assign oZeroCount = r_zcnt;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed scoreboard bench for alu_issue_stage; a second instance with a 2-bit
// zero counter shares all stimulus to exercise counter saturation.
module tb_alu_issue_stage;

    localparam int unsigned W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic         use_acc;
    logic         acc_clr;
    logic         ready;

    logic         rdy1, ov1, oz1, oil1, luz1;
    logic [W-1:0] lua1, lub1, lux1, ox1;
    logic [2:0]   luop1;
    logic [7:0]   zc1;

    logic         rdy2, ov2, oz2, oil2, luz2;
    logic [W-1:0] lua2, lub2, lux2, ox2;
    logic [2:0]   luop2;
    logic [1:0]   zc2;

    // Behavioural stand-in for the external logic unit.
    function automatic logic [W-1:0] lu_ref(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        case (o)
            3'b000:  return ~x;
            3'b001:  return ~y;
            3'b010:  return x | y;
            3'b011:  return x & y;
            3'b100:  return x ^ y;
            default: return '0;
        endcase
    endfunction

    assign lux1 = lu_ref(luop1, lua1, lub1);
    assign luz1 = (lux1 == '0);
    assign lux2 = lu_ref(luop2, lua2, lub2);
    assign luz2 = (lux2 == '0);

    alu_issue_stage dut (
        .iClk(clk), .iRstN(rst_n), .iValid(valid), .oReady(rdy1),
        .iA(a), .iB(b), .iOpcode(op), .iUseAcc(use_acc), .iAccClr(acc_clr),
        .oLuA(lua1), .oLuB(lub1), .oLuOpcode(luop1), .iLuX(lux1), .iLuZero(luz1),
        .oValid(ov1), .iReady(ready), .oX(ox1), .oZero(oz1), .oIllegal(oil1),
        .oZeroCount(zc1)
    );

    alu_issue_stage #(.WIDTH(16), .ZCNT_W(2)) dut_sat (
        .iClk(clk), .iRstN(rst_n), .iValid(valid), .oReady(rdy2),
        .iA(a), .iB(b), .iOpcode(op), .iUseAcc(use_acc), .iAccClr(acc_clr),
        .oLuA(lua2), .oLuB(lub2), .oLuOpcode(luop2), .iLuX(lux2), .iLuZero(luz2),
        .oValid(ov2), .iReady(ready), .oX(ox2), .oZero(oz2), .oIllegal(oil2),
        .oZeroCount(zc2)
    );

    typedef struct {
        logic [W-1:0] x;
        logic         z;
        logic         il;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   m_zc1    = 0;
    int   m_zc2    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Wait for oReady, present one request for one accepted edge, then check the EXEC view.
    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic [2:0] top,
                         input logic ua, input logic clr, input logic [W-1:0] eb, input logic [W-1:0] ex);
        int   n;
        exp_t e;
        n = 0;
        while (!rdy1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("issue_ready", 32'(rdy1), 32'h1);
        valid   = 1'b1;
        a       = ta;
        b       = tb_v;
        op      = top;
        use_acc = ua;
        acc_clr = clr;
        @(posedge clk); #1;
        valid   = 1'b0;
        use_acc = 1'b0;
        acc_clr = 1'b0;
        chk("lu_a", 32'(lua1), 32'(ta));
        chk("lu_b", 32'(lub1), 32'(eb));
        chk("lu_op", 32'(luop1), 32'(top));
        chk("sat_lu_b", 32'(lub2), 32'(eb));
        chk("exec_no_valid", 32'(ov1), 32'h0);
        chk("exec_not_ready", 32'(rdy1), 32'h0);
        e.x  = ex;
        e.il = (top > 3'b100);
        e.z  = (ex == '0);
        q.push_back(e);
        if (!e.il && e.z) begin
            if (m_zc1 < 255) m_zc1++;
            if (m_zc2 < 3) m_zc2++;
        end
    endtask

    // Wait for oValid and compare against the scoreboard head.
    task automatic collect(input bit chk_lat);
        int   n;
        exp_t e;
        n = 0;
        while (!ov1 && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk("valid_seen", 32'(ov1), 32'h1);
        if (chk_lat) chk("latency_edges", 32'(n), 32'h1);
        if (q.size() == 0) begin
            chk("scoreboard_empty", 32'(q.size()), 32'h1);
        end else begin
            e = q.pop_front();
            chk("x", 32'(ox1), 32'(e.x));
            chk("zero", 32'(oz1), 32'(e.z));
            chk("illegal", 32'(oil1), 32'(e.il));
            chk("zcount", 32'(zc1), 32'(m_zc1));
            chk("sat_valid", 32'(ov2), 32'h1);
            chk("sat_x", 32'(ox2), 32'(e.x));
            chk("sat_zcount", 32'(zc2), 32'(m_zc2));
        end
    endtask

    task automatic retire();
        @(posedge clk); #1;
        chk("retired", 32'(ov1), 32'h0);
        chk("ready_back", 32'(rdy1), 32'h1);
    endtask

    initial begin
        rst_n   = 1'b0;
        valid   = 1'b1;
        a       = 16'h1234;
        b       = 16'h5678;
        op      = 3'b010;
        use_acc = 1'b0;
        acc_clr = 1'b0;
        ready   = 1'b1;

        // Reset state; a held iValid must not be captured.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(ov1), 32'h0);
        chk("rst_x", 32'(ox1), 32'h0);
        chk("rst_zero", 32'(oz1), 32'h0);
        chk("rst_illegal", 32'(oil1), 32'h0);
        chk("rst_ready", 32'(rdy1), 32'h1);
        chk("rst_zcount", 32'(zc1), 32'h0);
        chk("rst_lu_a", 32'(lua1), 32'h0);
        @(negedge clk);
        valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        issue(16'h00F0, 16'h0F0F, 3'b010, 1'b0, 1'b0, 16'h0F0F, 16'h0FFF);
        collect(1'b1);
        retire();
        issue(16'h00F0, 16'h0F0F, 3'b011, 1'b0, 1'b0, 16'h0F0F, 16'h0000);
        collect(1'b1);
        retire();
        issue(16'hFFFF, 16'h0F0F, 3'b000, 1'b0, 1'b0, 16'h0F0F, 16'h0000);
        collect(1'b1);
        retire();

        // Accumulator chaining.
        issue(16'h1200, 16'h0034, 3'b010, 1'b0, 1'b0, 16'h0034, 16'h1234);
        collect(1'b1);
        retire();
        issue(16'h00FF, 16'h0000, 3'b100, 1'b1, 1'b0, 16'h1234, 16'h12CB);
        collect(1'b1);
        retire();

        // Back-pressure: result held, stray requests ignored.
        ready = 1'b0;
        issue(16'h0F00, 16'h00F0, 3'b010, 1'b0, 1'b0, 16'h00F0, 16'h0FF0);
        collect(1'b1);
        for (int i = 0; i < 5; i++) begin
            valid = 1'b1;
            a     = 16'hFFFF;
            op    = 3'b000;
            @(posedge clk); #1;
            chk("bp_valid", 32'(ov1), 32'h1);
            chk("bp_x", 32'(ox1), 32'h0FF0);
            chk("bp_ready", 32'(rdy1), 32'h0);
            chk("bp_lu_a", 32'(lua1), 32'h0F00);
        end
        valid = 1'b0;
        ready = 1'b1;
        retire();
        @(posedge clk); #1;
        chk("bp_no_capture", 32'(ov1), 32'h0);

        // Illegal opcode leaves the accumulator at 0x0FF0.
        issue(16'hAAAA, 16'h5555, 3'b110, 1'b0, 1'b0, 16'h5555, 16'h0000);
        collect(1'b1);
        retire();
        issue(16'h0000, 16'h0000, 3'b010, 1'b1, 1'b0, 16'h0FF0, 16'h0FF0);
        collect(1'b1);
        retire();

        // Clear on the capture edge wins over the accumulator read.
        issue(16'h0001, 16'hFFFF, 3'b010, 1'b1, 1'b1, 16'h0000, 16'h0001);
        collect(1'b1);
        retire();

        // Asynchronous reset in EXEC, with no clock edge in between.
        issue(16'h00F0, 16'h0F0F, 3'b010, 1'b0, 1'b0, 16'h0F0F, 16'h0FFF);
        chk("pre_rst_x", 32'(ox1), 32'h0001);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(ov1), 32'h0);
        chk("arst_x", 32'(ox1), 32'h0);
        chk("arst_zcount", 32'(zc1), 32'h0);
        chk("arst_ready", 32'(rdy1), 32'h1);
        chk("arst_lu_b", 32'(lub1), 32'h0);
        q.delete();
        m_zc1 = 0;
        m_zc2 = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        issue(16'h00F0, 16'h0F0F, 3'b010, 1'b0, 1'b0, 16'h0F0F, 16'h0FFF);
        collect(1'b1);
        retire();

        // Five zero results: 8-bit counter reaches 5, 2-bit counter stops at 3.
        for (int i = 0; i < 5; i++) begin
            issue(16'h0000, 16'h0000, 3'b011, 1'b0, 1'b0, 16'h0000, 16'h0000);
            collect(1'b0);
            retire();
        end
        chk("zc_final", 32'(zc1), 32'd5);
        chk("zc_saturated", 32'(zc2), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
